// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: walks start/data/parity/stop, drives the serializer
// shift enable and busy lock, and registers the muxed serial line.
module uart_tx_ctrl #(
  parameter int Data_Width = 8  // serializer counter is 3 bits, so only 8 works
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Data_Width-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Ser_Done,
  input  logic                  Ser_Data,
  output logic                  Ser_En,
  output logic                  Busy,
  output logic                  TX_OUT
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SEL_HIGH  = 2'd0,
    SEL_START = 2'd1,
    SEL_DATA  = 2'd2,
    SEL_PAR   = 2'd3
  } sel_e;

  state_e state, state_nxt;
  sel_e   sel;
  logic   par_en_q, par_typ_q, par_bit;
  logic   accept;
  logic   tx_mux;

  // A frame is only taken in IDLE; the serializer loads on the same edge
  // because Busy is low there.
  assign accept = (state == IDLE) && Data_Valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bit   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_bit   <= (^P_Data) ^ PAR_TYP;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b1;
    Ser_En    = 1'b0;
    sel       = SEL_HIGH;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Data_Valid) state_nxt = START;
      end
      START: begin
        sel       = SEL_START;
        state_nxt = DATA;
      end
      DATA: begin
        Ser_En = 1'b1;
        sel    = SEL_DATA;
        if (Ser_Done) state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        sel       = SEL_PAR;
        state_nxt = STOP;
      end
      STOP: begin
        state_nxt = IDLE;
      end
      default: begin
        Busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    tx_mux = 1'b1;
    case (sel)
      SEL_START: tx_mux = 1'b0;
      SEL_DATA:  tx_mux = Ser_Data;
      SEL_PAR:   tx_mux = par_bit;
      default:   tx_mux = 1'b1;
    endcase
  end

  // Line is registered, so it trails the state by one bit period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) TX_OUT <= 1'b1;
    else      TX_OUT <= tx_mux;
  end

  logic unused_par_typ_q;
  assign unused_par_typ_q = par_typ_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: serializer model, frame scoreboard fed by a vector
// table, plus back-to-back and mid-frame reset sequences.
module tb_uart_tx_ctrl;

  logic       clk, rst;
  logic [7:0] P_Data;
  logic       Data_Valid, PAR_EN, PAR_TYP;
  logic       Ser_Done, Ser_Data, Ser_En, Busy, TX_OUT;

  typedef struct {
    logic [7:0]  data;
    logic        pen, ptyp;
    logic        toggle;   // flip PAR_EN/PAR_TYP mid-frame
    logic        pulse;    // Data_Valid pulses while busy and in STOP
    logic        spur;     // spurious Ser_Done in START and STOP
    int          len;
    logic [0:10] bits;     // expected line bits in send order
  } vec_t;

  int tests = 0;
  int fails = 0;

  vec_t fq[$];
  int   blen_q[$];
  vec_t vecs[8];
  vec_t cur;
  logic mon_en = 1'b0;
  logic in_frame = 1'b0;
  int   idx = 0, busy_run = 0, en_run = 0;

  logic [7:0] sh;
  logic [2:0] cnt;
  logic       force_done;

  uart_tx_ctrl #(.Data_Width(8)) dut (
    .clk(clk), .rst(rst), .P_Data(P_Data), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Ser_Done(Ser_Done),
    .Ser_Data(Ser_Data), .Ser_En(Ser_En), .Busy(Busy), .TX_OUT(TX_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit serializer: loads when not busy, shifts LSB-first on Ser_En
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh  <= 8'h00;
      cnt <= 3'd0;
    end else if (!Busy && Data_Valid) begin
      sh  <= P_Data;
      cnt <= 3'd0;
    end else if (Ser_En) begin
      sh  <= sh >> 1;
      cnt <= cnt + 3'd1;
    end
  end
  assign Ser_Data = sh[0];
  assign Ser_Done = (cnt == 3'd7) || force_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: frame bits, Busy run length and Ser_En run length per frame
  initial forever begin
    @(negedge clk);
    if (!mon_en) begin
      in_frame = 1'b0;
      idx      = 0;
      busy_run = 0;
      en_run   = 0;
    end else begin
      if (Busy === 1'b1) busy_run++;
      else if (busy_run != 0) begin
        if (blen_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL busy_extra: got run %0d expected none", busy_run);
        end else chk("busy_len", busy_run, blen_q.pop_front());
        busy_run = 0;
      end
      if (Ser_En === 1'b1) en_run++;
      else if (en_run != 0) begin
        chk("ser_en_len", en_run, 8);
        en_run = 0;
      end
      if (!in_frame && TX_OUT === 1'b0) begin
        if (fq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_frame: got start bit expected idle line");
        end else begin
          cur      = fq.pop_front();
          in_frame = 1'b1;
          idx      = 0;
        end
      end
      if (in_frame) begin
        chk($sformatf("tx_%02h_bit%0d", cur.data, idx), TX_OUT, cur.bits[idx]);
        idx++;
        if (idx == cur.len) in_frame = 1'b0;
      end
    end
  end

  task automatic send_row(input vec_t v);
    @(negedge clk);
    P_Data = v.data; PAR_EN = v.pen; PAR_TYP = v.ptyp; Data_Valid = 1'b1;
    fq.push_back(v);
    blen_q.push_back(v.len);
    @(posedge clk);
    for (int c = 1; c <= v.len + 2; c++) begin
      @(negedge clk);
      Data_Valid = v.pulse && (c == 5 || c == v.len);
      if (v.pulse) P_Data = 8'h00;
      if (v.toggle && c == 3) begin
        PAR_EN  = ~v.pen;
        PAR_TYP = ~v.ptyp;
      end
      force_done = v.spur && (c == 1 || c == v.len);
      @(posedge clk);
    end
    @(negedge clk);
    Data_Valid = 1'b0;
    force_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   lows;
    vecs[0] = '{data:8'hA5, pen:1, ptyp:0, toggle:0, pulse:0, spur:0, len:11, bits:11'b01010010101};
    vecs[1] = '{data:8'h01, pen:1, ptyp:1, toggle:0, pulse:0, spur:0, len:11, bits:11'b01000000001};
    vecs[2] = '{data:8'h01, pen:1, ptyp:0, toggle:0, pulse:0, spur:0, len:11, bits:11'b01000000011};
    vecs[3] = '{data:8'h3C, pen:0, ptyp:0, toggle:1, pulse:0, spur:0, len:10, bits:11'b00011110010};
    vecs[4] = '{data:8'h00, pen:1, ptyp:1, toggle:0, pulse:1, spur:0, len:11, bits:11'b00000000011};
    vecs[5] = '{data:8'hFF, pen:1, ptyp:0, toggle:0, pulse:0, spur:1, len:11, bits:11'b01111111101};
    vecs[6] = '{data:8'h80, pen:0, ptyp:1, toggle:1, pulse:1, spur:0, len:10, bits:11'b00000000110};
    vecs[7] = '{data:8'h96, pen:1, ptyp:1, toggle:1, pulse:0, spur:0, len:11, bits:11'b00110100111};

    rst = 1'b1; P_Data = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    force_done = 1'b0;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_ser_en", Ser_En, 0);
    rst = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_tx", i), TX_OUT, 1);
      chk($sformatf("idle%0d_busy", i), Busy, 0);
      chk($sformatf("idle%0d_ser_en", i), Ser_En, 0);
    end

    foreach (vecs[i]) send_row(vecs[i]);

    // Data_Valid held high: frames 1 idle cycle apart, 3 accepted in 23 edges
    v = '{data:8'hFF, pen:0, ptyp:0, toggle:0, pulse:0, spur:0, len:10, bits:11'b01111111110};
    @(negedge clk);
    P_Data = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fq.push_back(v);
      blen_q.push_back(10);
    end
    lows = 0;
    for (int e = 0; e <= 22; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e <= 21 && Busy === 1'b0) lows++;
    end
    chk("b2b_idle_cycles", lows, 2);
    chk("b2b_third_busy", Busy, 1);
    Data_Valid = 1'b0;
    repeat (14) @(negedge clk);

    // Reset during DATA bit 4 of an 0xA5 frame
    @(posedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    P_Data = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Data_Valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_ser_en", Ser_En, 1);
    chk("pre_rst_tx_bit3", TX_OUT, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", TX_OUT, 1);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_ser_en", Ser_En, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;
    send_row('{data:8'h55, pen:1, ptyp:0, toggle:0, pulse:0, spur:0, len:11, bits:11'b01010101001});

    for (int i = 0; i < 60 && (fq.size() != 0 || in_frame); i++) @(negedge clk);
    chk("frames_left", fq.size(), 0);
    chk("busy_runs_left", blen_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
